// File: rtl/edge_table_writer_if.sv
// Host-stream and RAM-write-port bundle for edge_table_writer.
// The host/loader side uses the master modport; the writer uses slave.
interface edge_table_writer_if #(
    parameter int ADDR_W = 11
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_first;
    logic [7:0]        in_second;
    logic              in_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;

    modport master (
        output in_valid, in_first, in_second, in_last,
        input  in_ready, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  in_valid, in_first, in_second, in_last,
        output in_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/edge_table_writer.sv
// Edge RAM writer: streams normalised pose pairs to addresses 0.. and pads the tail with PAD_WORD.
// Optional feature macro EDGE_CHECK_EN: bad entries (pose out of range or A == B) are written as PAD_WORD.
module edge_table_writer #(
    parameter int          EDGE_NUM = 1035,
    parameter int          NUM_POSE = 66,
    parameter int          ADDR_W   = 11,
    parameter logic [15:0] PAD_WORD = 16'hFFFF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    edge_table_writer_if.slave  bus,
    output logic [ADDR_W-1:0]   edge_count,
    output logic                done,
    output logic [1:0]          error,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PAD  = 3'd2,
        S_DONE = 3'd3
    } state_t;

`ifdef EDGE_CHECK_EN
    localparam bit LP_CHECK = 1'b1;
`else
    localparam bit LP_CHECK = 1'b0;
`endif

    // One extra bit so the pointer can hold EDGE_NUM even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(EDGE_NUM - 1);

    state_t              r_state;
    logic [ADDR_W:0]     r_wp;
    logic [ADDR_W-1:0]   r_edge_count;
    logic                r_done;
    logic [1:0]          r_error;
    logic                r_in_ready;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [15:0]         r_ram_wdata;

    logic                w_accept;
    logic                w_bad;

    function automatic logic [15:0] f_norm_pair(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? {a, b} : {b, a};
    endfunction

    function automatic logic f_bad_entry(input logic [7:0] a, input logic [7:0] b);
        return (a >= 8'(NUM_POSE)) || (b >= 8'(NUM_POSE)) || (a == b);
    endfunction

    // in_ready is only ever high in LOAD, so the handshake alone qualifies an accept.
    assign w_accept = bus.in_valid & r_in_ready;
    assign w_bad    = LP_CHECK && f_bad_entry(bus.in_first, bus.in_second);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_edge_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 2'b00;
            r_in_ready   <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_wp         <= '0;
                        r_edge_count <= '0;
                        r_error      <= 2'b00;
                        r_done       <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (start) r_error[1] <= 1'b1;
                    if (w_accept) begin
                        r_ram_we     <= 1'b1;
                        r_ram_addr   <= r_wp[ADDR_W-1:0];
                        r_ram_wdata  <= w_bad ? PAD_WORD : f_norm_pair(bus.in_first, bus.in_second);
                        r_wp         <= r_wp + 1'b1;
                        r_edge_count <= r_edge_count + 1'b1;
                        if (w_bad) r_error[0] <= 1'b1;
                        if (r_wp == LP_LAST) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (bus.in_last) begin
                            r_state    <= S_PAD;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    if (start) r_error[1] <= 1'b1;
                    r_ram_we    <= 1'b1;
                    r_ram_addr  <= r_wp[ADDR_W-1:0];
                    r_ram_wdata <= PAD_WORD;
                    r_wp        <= r_wp + 1'b1;
                    if (r_wp == LP_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign edge_count    = r_edge_count;
    assign done          = r_done;
    assign error         = r_error;
    assign state         = r_state;

endmodule

// File: tb/tb_edge_table_writer.sv
// Scoreboard bench for edge_table_writer: expected RAM writes are queued as entries are driven.
module tb_edge_table_writer;

    localparam int EDGE_NUM = 1035;
    localparam int ADDR_W   = 11;
`ifdef EDGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] edge_count;
    logic              done;
    logic [1:0]        error;
    logic [2:0]        state;

    edge_table_writer_if #(.ADDR_W(ADDR_W)) bus ();

    edge_table_writer #(
        .EDGE_NUM(EDGE_NUM), .NUM_POSE(66), .ADDR_W(ADDR_W), .PAD_WORD(16'hFFFF)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .bus(bus),
        .edge_count(edge_count), .done(done), .error(error), .state(state)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int m_wp     = 0;
    logic [ADDR_W+15:0] q[$];

    function automatic logic [15:0] m_word(input int a, input int b);
        if (CHK && (a >= 66 || b >= 66 || a == b)) return 16'hFFFF;
        if (a < b) return {a[7:0], b[7:0]};
        return {b[7:0], a[7:0]};
    endfunction

    // Advance one clock, then sample and score any RAM write.
    task automatic cycle();
        logic [ADDR_W+15:0] exp_w;
        @(posedge CLK);
        #1;
        if (bus.ram_we === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no write", bus.ram_addr, bus.ram_wdata);
            end else begin
                exp_w = q.pop_front();
                if ({bus.ram_addr, bus.ram_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL ram_write addr=%0d data=%h required addr=%0d data=%h",
                             bus.ram_addr, bus.ram_wdata, exp_w[ADDR_W+15:16], exp_w[15:0]);
                end
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        m_wp  = 0;
    endtask

    task automatic send(input int a, input int b, input logic last);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_before_send got=%b required=1", bus.in_ready);
        end
        q.push_back({m_wp[ADDR_W-1:0], m_word(a, b)});
        m_wp++;
        bus.in_valid  = 1'b1;
        bus.in_first  = a[7:0];
        bus.in_second = b[7:0];
        bus.in_last   = last;
        cycle();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    task automatic push_pad();
        while (m_wp < EDGE_NUM) begin
            q.push_back({m_wp[ADDR_W-1:0], 16'hFFFF});
            m_wp++;
        end
    endtask

    task automatic wait_done(input int budget, input int exp_cnt, input logic [1:0] exp_err);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout done=%b required=1", done);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes pending=%0d required=0", q.size());
        end
        checks++;
        if (edge_count !== exp_cnt[ADDR_W-1:0]) begin
            failures++;
            $display("FAIL edge_count got=%0d required=%0d", edge_count, exp_cnt);
        end
        checks++;
        if (error !== exp_err) begin
            failures++;
            $display("FAIL error got=%b required=%b", error, exp_err);
        end
        checks++;
        if (state !== 3'd3 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_state state=%0d in_ready=%b required state=3 in_ready=0", state, bus.in_ready);
        end
        repeat (3) cycle();
        checks++;
        if (bus.ram_we !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold ram_we=%b done=%b required ram_we=0 done=1", bus.ram_we, done);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) cycle();
        checks++;
        if ({state, done, error, edge_count, bus.ram_we, bus.in_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs state=%0d done=%b error=%b edge_count=%0d ram_we=%b in_ready=%b required all 0",
                     state, done, error, edge_count, bus.ram_we, bus.in_ready);
        end
        RST = 1'b0;
        cycle();
    endtask

    task automatic test_basic_pad();
        do_start();
        send(5, 2, 1'b0);
        send(7, 9, 1'b0);
        send(1, 3, 1'b1);
        push_pad();
        wait_done(1100, 3, 2'b00);
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < EDGE_NUM; i++) send(i % 66, (i + 1) % 66, 1'b0);
        checks++;
        if (q.size() != 0 || done !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_load pending=%0d done=%b in_ready=%b required 0/1/0", q.size(), done, bus.in_ready);
        end
        wait_done(5, EDGE_NUM, 2'b00);
    endtask

    task automatic test_bad_entry();
        do_start();
        send(70, 4, 1'b0);
        send(8, 8, 1'b1);
        push_pad();
        wait_done(1100, 2, {1'b0, CHK});
    endtask

    task automatic test_valid_gaps();
        do_start();
        send(10, 20, 1'b0);
        cycle();
        cycle();
        checks++;
        if (edge_count !== 11'd1 || state !== 3'd1) begin
            failures++;
            $display("FAIL gap_hold edge_count=%0d state=%0d required 1/1", edge_count, state);
        end
        send(30, 4, 1'b1);
        push_pad();
        wait_done(1100, 2, 2'b00);
    endtask

    task automatic test_start_busy_and_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) start = 1'b1;
            send(i + 20, 40 - i, 1'b0);
            start = 1'b0;
        end
        checks++;
        if (error !== 2'b10 || state !== 3'd1 || edge_count !== 11'd10) begin
            failures++;
            $display("FAIL start_ignored error=%b state=%0d edge_count=%0d required 10/1/10", error, state, edge_count);
        end
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        checks++;
        if ({state, done, error, edge_count, bus.ram_we, bus.in_ready} !== '0) begin
            failures++;
            $display("FAIL midload_reset state=%0d done=%b error=%b edge_count=%0d ram_we=%b in_ready=%b required all 0",
                     state, done, error, edge_count, bus.ram_we, bus.in_ready);
        end
        repeat (20) cycle();
        checks++;
        if (q.size() != 0 || state !== 3'd0) begin
            failures++;
            $display("FAIL after_reset pending=%0d state=%0d required 0/0", q.size(), state);
        end
    endtask

    task automatic test_restart();
        do_start();
        send(3, 1, 1'b0);
        start = 1'b1;
        send(60, 61, 1'b1);
        start = 1'b0;
        push_pad();
        wait_done(1100, 2, 2'b10);
        do_start();
        checks++;
        if (done !== 1'b0 || error !== 2'b00 || edge_count !== 11'd0 || state !== 3'd1) begin
            failures++;
            $display("FAIL restart done=%b error=%b edge_count=%0d state=%0d required 0/00/0/1", done, error, edge_count, state);
        end
        send(2, 9, 1'b1);
        push_pad();
        wait_done(1100, 1, 2'b00);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_first  = 8'd0;
        bus.in_second = 8'd0;
        bus.in_last   = 1'b0;
        test_reset();
        test_basic_pad();
        test_back_to_back();
        test_bad_entry();
        test_valid_gaps();
        test_start_busy_and_reset();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
